// File: rtl/z80fi_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : z80fi_seq_pkg
// Brief  : Shared types and state-field layout for the z80fi sequence checker.
// Rev    : 1.0
// ============================================================================
package z80fi_seq_pkg;

  localparam int STATE_W = 210;
  localparam int NFIELDS = 26;

  typedef enum logic [4:0] {
    F_IP   = 5'd0,  F_A    = 5'd1,  F_F    = 5'd2,  F_B    = 5'd3,
    F_C    = 5'd4,  F_D    = 5'd5,  F_E    = 5'd6,  F_H    = 5'd7,
    F_L    = 5'd8,  F_A2   = 5'd9,  F_F2   = 5'd10, F_B2   = 5'd11,
    F_C2   = 5'd12, F_D2   = 5'd13, F_E2   = 5'd14, F_H2   = 5'd15,
    F_L2   = 5'd16, F_IX   = 5'd17, F_IY   = 5'd18, F_SP   = 5'd19,
    F_I    = 5'd20, F_R    = 5'd21, F_IFF1 = 5'd22, F_IFF2 = 5'd23,
    F_RSV0 = 5'd24, F_RSV1 = 5'd25
  } field_e;

  // Reserved codes have zero width and never mismatch.
  localparam int c_FIELD_OFF [NFIELDS] = '{
    0, 16, 24, 32, 40, 48, 56, 64, 72, 80, 88, 96, 104,
    112, 120, 128, 136, 144, 160, 176, 192, 200, 208, 209, 210, 210
  };
  localparam int c_FIELD_W [NFIELDS] = '{
    16, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8,
    8, 8, 8, 8, 16, 16, 16, 8, 8, 1, 1, 0, 0
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAIL  = 2'd3
  } chk_state_e;

endpackage
`default_nettype wire

// File: rtl/z80fi_state_cmp.sv
`default_nettype none
// ============================================================================
// Module : z80fi_state_cmp
// Brief  : Field-wise compare of one state pair; reports lowest mismatching field.
// Rev    : 1.0
// ============================================================================
module z80fi_state_cmp
  import z80fi_seq_pkg::*;
#(
  parameter logic [NFIELDS-1:0] IGNORE_MASK = '0
) (
  input  logic [STATE_W-1:0] state_in,
  input  logic [STATE_W-1:0] state_ref,
  output logic               mismatch,
  output logic [4:0]         field
);

  logic [NFIELDS-1:0] w_diff;

  for (genvar f = 0; f < NFIELDS; f++) begin : g_field
    if (c_FIELD_W[f] > 0) begin : g_live
      assign w_diff[f] = (state_in[c_FIELD_OFF[f] +: c_FIELD_W[f]] !=
                          state_ref[c_FIELD_OFF[f] +: c_FIELD_W[f]]) & ~IGNORE_MASK[f];
    end else begin : g_rsv
      assign w_diff[f] = 1'b0;
    end
  end

  always_comb begin
    field = '0;
    for (int f = NFIELDS - 1; f >= 0; f--) begin
      if (w_diff[f]) field = 5'(f);
    end
  end

  assign mismatch = |w_diff;

endmodule
`default_nettype wire

// File: rtl/z80fi_seq_check.sv
`default_nettype none
// ============================================================================
// Module : z80fi_seq_check
// Brief  : Checks retirement chaining (in == previous out) over DEPTH retirements.
// Rev    : 1.0
// ============================================================================
module z80fi_seq_check
  import z80fi_seq_pkg::*;
#(
  parameter int                 NRET         = 1,
  parameter int                 DEPTH        = 8,
  parameter logic [NFIELDS-1:0] IGNORE_MASK  = '0,
  parameter bit                 STOP_ON_FAIL = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic [NRET-1:0]         z80fi_valid,
  input  logic [NRET*STATE_W-1:0] z80fi_state_in,
  input  logic [NRET*STATE_W-1:0] z80fi_state_out,
  output logic                    check,
  output logic                    busy,
  output logic                    fail,
  output logic                    fail_proto,
  output logic [1:0]              fail_chan,
  output logic [4:0]              fail_field,
  output logic [7:0]              retired
);

  chk_state_e         r_state, w_state_nxt;
  logic [STATE_W-1:0] r_shadow;
  logic               r_shadow_valid;
  logic [7:0]         r_retired;
  logic               r_fail, r_fail_proto;
  logic [1:0]         r_fail_chan;
  logic [4:0]         r_fail_field;

  logic [NRET-1:0]    w_cmp_mm;
  logic [4:0]         w_cmp_fld [NRET];
  logic [2:0]         w_nvalid;
  logic               w_proto;
  logic [1:0]         w_hole;
  logic               w_fail_found;
  logic [1:0]         w_fail_idx;
  logic [4:0]         w_fail_fld;
  logic [2:0]         w_accepted;
  logic [STATE_W-1:0] w_last_out;
  logic [8:0]         w_sum;
  logic               w_hit;
  logic               w_mm_err;

  // Channel 0 chains from the shadow, channel k from channel k-1's output.
  for (genvar k = 0; k < NRET; k++) begin : g_chan
    logic [STATE_W-1:0] w_ref;
    if (k == 0) begin : g_first
      assign w_ref = r_shadow;
    end else begin : g_next
      assign w_ref = z80fi_state_out[(k-1)*STATE_W +: STATE_W];
    end
    z80fi_state_cmp #(.IGNORE_MASK(IGNORE_MASK)) u_cmp (
      .state_in  (z80fi_state_in[k*STATE_W +: STATE_W]),
      .state_ref (w_ref),
      .mismatch  (w_cmp_mm[k]),
      .field     (w_cmp_fld[k])
    );
  end

  // Leading-ones count; any valid bit above the first hole is a protocol error.
  always_comb begin
    logic v_gap;
    v_gap    = 1'b0;
    w_nvalid = '0;
    w_proto  = 1'b0;
    w_hole   = '0;
    for (int k = 0; k < NRET; k++) begin
      if (z80fi_valid[k]) begin
        if (v_gap) w_proto = 1'b1;
        else       w_nvalid = w_nvalid + 3'd1;
      end else if (!v_gap) begin
        v_gap  = 1'b1;
        w_hole = 2'(k);
      end
    end
  end

  always_comb begin
    w_fail_found = 1'b0;
    w_fail_idx   = '0;
    w_fail_fld   = '0;
    w_accepted   = w_proto ? 3'd0 : w_nvalid;
    w_last_out   = '0;
    for (int k = 0; k < NRET; k++) begin
      if (!w_proto && !w_fail_found && (3'(k) < w_nvalid) && w_cmp_mm[k] &&
          ((k != 0) || r_shadow_valid)) begin
        w_fail_found = 1'b1;
        w_fail_idx   = 2'(k);
        w_fail_fld   = w_cmp_fld[k];
        w_accepted   = 3'(k);
      end
      if (3'(k + 1) == w_nvalid) w_last_out = z80fi_state_out[k*STATE_W +: STATE_W];
    end
    w_sum    = {1'b0, r_retired} + {6'd0, w_accepted};
    w_hit    = (w_sum >= 9'(DEPTH));
    // A mismatch on a channel past the DEPTH-th retirement is ignored.
    w_mm_err = w_fail_found && !w_hit;
  end

  assign check = (r_state == ST_TRACK) && !w_proto && w_hit;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (arm) w_state_nxt = ST_TRACK;
      ST_TRACK: begin
        if (check)                                           w_state_nxt = ST_DONE;
        else if (STOP_ON_FAIL && (w_proto || w_mm_err))      w_state_nxt = ST_FAIL;
      end
      default:  w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
      r_retired      <= '0;
      r_fail         <= 1'b0;
      r_fail_proto   <= 1'b0;
      r_fail_chan    <= '0;
      r_fail_field   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_TRACK) begin
        if (w_proto) begin
          r_fail_proto <= 1'b1;
          if (!r_fail) begin
            r_fail       <= 1'b1;
            r_fail_chan  <= w_hole;
            r_fail_field <= '0;
          end
        end else begin
          r_retired <= w_hit ? 8'(DEPTH) : w_sum[7:0];
          if (w_mm_err && !r_fail) begin
            r_fail       <= 1'b1;
            r_fail_chan  <= w_fail_idx;
            r_fail_field <= w_fail_fld;
          end
          if (w_nvalid != 3'd0) begin
            r_shadow       <= w_last_out;
            r_shadow_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign busy       = (r_state == ST_TRACK);
  assign fail       = r_fail;
  assign fail_proto = r_fail_proto;
  assign fail_chan  = r_fail_chan;
  assign fail_field = r_fail_field;
  assign retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_z80fi_seq_check.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_z80fi_seq_check
// Brief  : Directed vector table, hand sequences and random model check.
// Rev    : 1.0
// ============================================================================
module tb_z80fi_seq_check;

  localparam int SW = 210;
  localparam int FW [24] = '{16, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8,
                             16, 16, 16, 8, 8, 1, 1};
  localparam int BDEPTH = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   errors = 0;
  int   checks = 0;

  // NRET=1 bus shared by dut_a (no mask) and dut_m (R masked)
  logic s1_arm; logic [0:0] s1_valid; logic [SW-1:0] s1_in, s1_out;
  // NRET=2 bus (dut_c) and NRET=4 bus (dut_b)
  logic s2_arm; logic [1:0] s2_valid; logic [2*SW-1:0] s2_in, s2_out;
  logic s4_arm; logic [3:0] s4_valid; logic [4*SW-1:0] s4_in, s4_out;

  logic a_chk, a_busy, a_fail, a_proto; logic [1:0] a_chan; logic [4:0] a_fld; logic [7:0] a_ret;
  logic m_chk, m_busy, m_fail, m_proto; logic [1:0] m_chan; logic [4:0] m_fld; logic [7:0] m_ret;
  logic c_chk, c_busy, c_fail, c_proto; logic [1:0] c_chan; logic [4:0] c_fld; logic [7:0] c_ret;
  logic b_chk, b_busy, b_fail, b_proto; logic [1:0] b_chan; logic [4:0] b_fld; logic [7:0] b_ret;

  z80fi_seq_check #(.NRET(1), .DEPTH(4), .IGNORE_MASK(26'h0), .STOP_ON_FAIL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .arm(s1_arm), .z80fi_valid(s1_valid),
    .z80fi_state_in(s1_in), .z80fi_state_out(s1_out), .check(a_chk), .busy(a_busy),
    .fail(a_fail), .fail_proto(a_proto), .fail_chan(a_chan), .fail_field(a_fld), .retired(a_ret));

  z80fi_seq_check #(.NRET(1), .DEPTH(4), .IGNORE_MASK(26'h1 << 21), .STOP_ON_FAIL(1'b1)) dut_m (
    .clk(clk), .reset(reset), .arm(s1_arm), .z80fi_valid(s1_valid),
    .z80fi_state_in(s1_in), .z80fi_state_out(s1_out), .check(m_chk), .busy(m_busy),
    .fail(m_fail), .fail_proto(m_proto), .fail_chan(m_chan), .fail_field(m_fld), .retired(m_ret));

  z80fi_seq_check #(.NRET(2), .DEPTH(3), .IGNORE_MASK(26'h0), .STOP_ON_FAIL(1'b1)) dut_c (
    .clk(clk), .reset(reset), .arm(s2_arm), .z80fi_valid(s2_valid),
    .z80fi_state_in(s2_in), .z80fi_state_out(s2_out), .check(c_chk), .busy(c_busy),
    .fail(c_fail), .fail_proto(c_proto), .fail_chan(c_chan), .fail_field(c_fld), .retired(c_ret));

  z80fi_seq_check #(.NRET(4), .DEPTH(BDEPTH), .IGNORE_MASK(26'h0), .STOP_ON_FAIL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .arm(s4_arm), .z80fi_valid(s4_valid),
    .z80fi_state_in(s4_in), .z80fi_state_out(s4_out), .check(b_chk), .busy(b_busy),
    .fail(b_fail), .fail_proto(b_proto), .fail_chan(b_chan), .fail_field(b_fld), .retired(b_ret));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int foff(input int f);
    int o = 0;
    for (int i = 0; i < f; i++) o += FW[i];
    return o;
  endfunction

  function automatic logic [SW-1:0] mk(input int ip, input int a, input int r);
    logic [SW-1:0] s = '0;
    s[15:0]         = ip[15:0];
    s[foff(1) +: 8] = a[7:0];
    s[foff(21) +: 8] = r[7:0];
    return s;
  endfunction

  // Lowest field index in which x and y differ, or -1.
  function automatic int first_diff(input logic [SW-1:0] x, input logic [SW-1:0] y);
    int o = 0;
    for (int f = 0; f < 24; f++) begin
      for (int b = 0; b < FW[f]; b++) if (x[o+b] != y[o+b]) return f;
      o += FW[f];
    end
    return -1;
  endfunction

  function automatic logic [SW-1:0] rnd_state();
    logic [223:0] t = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom()};
    return t[SW-1:0];
  endfunction

  typedef struct {
    bit rst; bit arm; bit v;
    int ip_i, ip_o, a_i, a_o, r_i, r_o;
    int ea_chk, ea_ret, ea_busy, ea_fail, ea_fld;
    int em_chk, em_ret, em_fail;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t V(input bit rst, input bit arm, input bit v,
                             input int ip_i, input int ip_o, input int a_i, input int a_o,
                             input int r_i, input int r_o,
                             input int ea_chk, input int ea_ret, input int ea_busy,
                             input int ea_fail, input int ea_fld,
                             input int em_chk, input int em_ret, input int em_fail);
    vec_t t;
    t.rst = rst; t.arm = arm; t.v = v;
    t.ip_i = ip_i; t.ip_o = ip_o; t.a_i = a_i; t.a_o = a_o; t.r_i = r_i; t.r_o = r_o;
    t.ea_chk = ea_chk; t.ea_ret = ea_ret; t.ea_busy = ea_busy; t.ea_fail = ea_fail;
    t.ea_fld = ea_fld; t.em_chk = em_chk; t.em_ret = em_ret; t.em_fail = em_fail;
    return t;
  endfunction

  task automatic drive1(input bit arm, input bit v, input int ipi, input int ipo);
    @(posedge clk); #1;
    reset = 1'b0; s1_arm = arm; s1_valid = v; s1_in = mk(ipi, 0, 0); s1_out = mk(ipo, 0, 0);
    @(negedge clk);
  endtask

  task automatic drive2(input bit arm, input logic [1:0] v, input int i0, input int o0,
                        input int i1, input int o1);
    @(posedge clk); #1;
    reset = 1'b0; s2_arm = arm; s2_valid = v;
    s2_in  = {mk(i1, 0, 0), mk(i0, 0, 0)};
    s2_out = {mk(o1, 0, 0), mk(o0, 0, 0)};
    @(negedge clk);
  endtask

  task automatic drive4(input bit arm, input logic [3:0] v, input int i0, input int o0);
    @(posedge clk); #1;
    reset = 1'b0; s4_arm = arm; s4_valid = v;
    s4_in = '0; s4_out = '0;
    for (int k = 0; k < 4; k++) begin
      s4_in[k*SW +: SW]  = mk(i0 + 2*k, 0, 0);
      s4_out[k*SW +: SW] = mk(o0 + 2*k, 0, 0);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Random-run model state
  int            md_phase, md_ret, md_fail, md_proto, md_chan, md_fld, md_have;
  logic [SW-1:0] md_prev;

  initial begin
    logic [SW-1:0] rin [4];
    logic [SW-1:0] rout [4];
    logic [SW-1:0] g_last;
    logic [3:0]    v;
    int n, ec, d;
    bit legal;

    reset = 1'b1;
    s1_arm = 0; s1_valid = 0; s1_in = '0; s1_out = '0;
    s2_arm = 0; s2_valid = 0; s2_in = '0; s2_out = '0;
    s4_arm = 0; s4_valid = 0; s4_in = '0; s4_out = '0;

    // rst arm v | ip_i ip_o a_i a_o r_i r_o | a: chk ret busy fail fld | m: chk ret fail
    tab.push_back(V(1,0,0, 0,0,0,0,0,0,          0,0,0,0,0,   0,0,0));
    tab.push_back(V(0,1,1, 'h55,'h66,0,0,0,0,    0,0,0,0,0,   0,0,0));
    tab.push_back(V(0,0,1, 0,1,0,0,0,0,          0,0,1,0,0,   0,0,0));
    tab.push_back(V(0,0,1, 1,3,0,0,0,0,          0,1,1,0,0,   0,1,0));
    tab.push_back(V(0,0,0, 0,0,0,0,0,0,          0,2,1,0,0,   0,2,0));
    tab.push_back(V(0,0,1, 3,4,0,0,0,0,          0,2,1,0,0,   0,2,0));
    tab.push_back(V(0,0,1, 4,7,0,0,0,0,          1,3,1,0,0,   1,3,0));
    tab.push_back(V(0,0,0, 0,0,0,0,0,0,          0,4,0,0,0,   0,4,0));
    tab.push_back(V(0,0,1, 'h99,'h9A,0,0,0,0,    0,4,0,0,0,   0,4,0));
    tab.push_back(V(0,1,0, 0,0,0,0,0,0,          0,4,0,0,0,   0,4,0));
    tab.push_back(V(0,0,0, 0,0,0,0,0,0,          0,4,0,0,0,   0,4,0));
    // A-field break on the second retirement
    tab.push_back(V(1,0,0, 0,0,0,0,0,0,          0,0,0,0,0,   0,0,0));
    tab.push_back(V(0,1,0, 0,0,0,0,0,0,          0,0,0,0,0,   0,0,0));
    tab.push_back(V(0,0,1, 0,1,0,'h13,0,0,       0,0,1,0,0,   0,0,0));
    tab.push_back(V(0,0,1, 1,2,'h12,'h14,0,0,    0,1,1,0,0,   0,1,0));
    tab.push_back(V(0,0,0, 0,0,0,0,0,0,          0,1,0,1,1,   0,1,1));
    tab.push_back(V(0,0,1, 2,3,'h14,'h14,0,0,    0,1,0,1,1,   0,1,1));
    tab.push_back(V(0,0,0, 0,0,0,0,0,0,          0,1,0,1,1,   0,1,1));
    // R differs by 0x7F: flagged by dut_a, masked in dut_m
    tab.push_back(V(1,0,0, 0,0,0,0,0,0,          0,0,0,0,0,   0,0,0));
    tab.push_back(V(0,1,0, 0,0,0,0,0,0,          0,0,0,0,0,   0,0,0));
    tab.push_back(V(0,0,1, 0,1,0,0,0,'h10,       0,0,1,0,0,   0,0,0));
    tab.push_back(V(0,0,1, 1,2,0,0,'h8F,'h90,    0,1,1,0,0,   0,1,0));
    tab.push_back(V(0,0,1, 2,3,0,0,'h90,'h91,    0,1,0,1,21,  0,2,0));
    tab.push_back(V(0,0,1, 3,4,0,0,'h91,'h92,    0,1,0,1,21,  1,3,0));
    tab.push_back(V(0,0,0, 0,0,0,0,0,0,          0,1,0,1,21,  0,4,0));

    for (int i = 0; i < tab.size(); i++) begin
      @(posedge clk); #1;
      reset = tab[i].rst; s1_arm = tab[i].arm; s1_valid = tab[i].v;
      s1_in  = mk(tab[i].ip_i, tab[i].a_i, tab[i].r_i);
      s1_out = mk(tab[i].ip_o, tab[i].a_o, tab[i].r_o);
      @(negedge clk);
      chk($sformatf("vec%0d a.check", i),   a_chk,  tab[i].ea_chk);
      chk($sformatf("vec%0d a.retired", i), a_ret,  tab[i].ea_ret);
      chk($sformatf("vec%0d a.busy", i),    a_busy, tab[i].ea_busy);
      chk($sformatf("vec%0d a.fail", i),    a_fail, tab[i].ea_fail);
      chk($sformatf("vec%0d a.field", i),   a_fld,  tab[i].ea_fld);
      chk($sformatf("vec%0d m.check", i),   m_chk,  tab[i].em_chk);
      chk($sformatf("vec%0d m.retired", i), m_ret,  tab[i].em_ret);
      chk($sformatf("vec%0d m.fail", i),    m_fail, tab[i].em_fail);
    end

    // Asynchronous reset in the middle of TRACK, then re-arm
    do_reset();
    drive1(1, 0, 0, 0);
    drive1(0, 1, 0, 1);
    drive1(0, 1, 1, 2);
    drive1(0, 1, 2, 3);
    drive1(0, 0, 0, 0);
    chk("midreset pre retired", a_ret, 3);
    #2 reset = 1'b1;
    #1;
    chk("midreset retired", a_ret, 0);
    chk("midreset busy", a_busy, 0);
    chk("midreset check", a_chk, 0);
    chk("midreset fail", a_fail, 0);
    drive1(1, 0, 0, 0);
    drive1(0, 1, 'h77, 'h10);
    chk("rearm busy", a_busy, 1);
    chk("rearm retired0", a_ret, 0);
    drive1(0, 1, 'h10, 'h11);
    chk("rearm retired1", a_ret, 1);
    drive1(0, 0, 0, 0);
    chk("rearm retired2", a_ret, 2);
    chk("rearm fail", a_fail, 0);

    // Two channels, DEPTH=3: check in the second cycle, count saturates at 3
    do_reset();
    drive2(1, 2'b00, 0, 0, 0, 0);
    drive2(0, 2'b11, 0, 1, 1, 2);
    chk("nret2 c1 check", c_chk, 0);
    chk("nret2 c1 retired", c_ret, 0);
    drive2(0, 2'b11, 2, 3, 3, 4);
    chk("nret2 c2 check", c_chk, 1);
    chk("nret2 c2 retired", c_ret, 2);
    drive2(0, 2'b00, 0, 0, 0, 0);
    chk("nret2 end retired", c_ret, 3);
    chk("nret2 end busy", c_busy, 0);
    chk("nret2 end fail", c_fail, 0);

    // Four channels: non-contiguous valid vector
    do_reset();
    drive4(1, 4'b0000, 0, 0);
    drive4(0, 4'b0001, 0, 1);
    drive4(0, 4'b0101, 1, 2);
    chk("proto check", b_chk, 0);
    chk("proto pre retired", b_ret, 1);
    drive4(0, 4'b0000, 0, 0);
    chk("proto fail_proto", b_proto, 1);
    chk("proto fail", b_fail, 1);
    chk("proto chan", b_chan, 1);
    chk("proto field", b_fld, 0);
    chk("proto retired", b_ret, 1);

    // Random chained traffic on the 4-channel, keep-counting instance
    for (int ep = 0; ep < 15; ep++) begin
      do_reset();
      md_phase = 0; md_ret = 0; md_fail = 0; md_proto = 0; md_chan = 0; md_fld = 0;
      md_have = 0; md_prev = '0; g_last = rnd_state();
      for (int cyc = 0; cyc < 40; cyc++) begin
        if ($urandom_range(0, 15) < 2) begin
          do v = 4'($urandom_range(0, 15)); while ((v & (v + 4'd1)) == 4'd0);
        end else begin
          v = 4'((1 << $urandom_range(0, 4)) - 1);
        end
        for (int k = 0; k < 4; k++) begin
          rout[k] = rnd_state();
          rin[k]  = (k == 0) ? g_last : rout[k-1];
          if ($urandom_range(0, 19) == 0) rin[k][$urandom_range(0, SW-1)] ^= 1'b1;
        end
        n = 0;
        while (n < 4 && v[n]) n++;
        legal = (v == 4'((1 << n) - 1));
        if (legal && n > 0) g_last = rout[n-1];

        @(posedge clk); #1;
        reset = 1'b0; s4_arm = 1'($urandom_range(0, 1)); s4_valid = v;
        for (int k = 0; k < 4; k++) begin
          s4_in[k*SW +: SW] = rin[k]; s4_out[k*SW +: SW] = rout[k];
        end
        @(negedge clk);
        chk("rnd busy",    b_busy,  (md_phase == 1) ? 1 : 0);
        chk("rnd retired", b_ret,   md_ret);
        chk("rnd fail",    b_fail,  md_fail);
        chk("rnd proto",   b_proto, md_proto);
        chk("rnd chan",    b_chan,  md_chan);
        chk("rnd field",   b_fld,   md_fld);

        ec = 0;
        if (md_phase == 0) begin
          if (s4_arm) md_phase = 1;
        end else if (md_phase == 1) begin
          if (!legal) begin
            md_proto = 1;
            if (!md_fail) begin md_fail = 1; md_chan = n; md_fld = 0; end
          end else begin
            for (int k = 0; k < n; k++) begin
              if (md_ret == BDEPTH) break;
              d = -1;
              if (k > 0)        d = first_diff(rin[k], rout[k-1]);
              else if (md_have) d = first_diff(rin[0], md_prev);
              if (d >= 0) begin
                if (!md_fail) begin md_fail = 1; md_chan = k; md_fld = d; end
                break;
              end
              md_ret++;
              if (md_ret == BDEPTH) begin ec = 1; md_phase = 2; end
            end
            if (n > 0) begin md_prev = rout[n-1]; md_have = 1; end
          end
        end
        chk("rnd check", b_chk, ec);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/z80fi_seq_check.md
Name: z80fi_seq_check

Overview:
- Sequential consistency checker for the Z80 formal interface (z80fi). Watches up to NRET retirements per cycle.
- Requires each retired instruction's input architectural state to equal the previous retirement's output state, field by field.
- Counts DEPTH consecutive consistent retirements, then pulses `check` so per-instruction checkers can fire on the final one.
- Sits beside the per-instruction checker in formal harnesses; also usable in simulation through its sticky fail outputs.

Parameters:
- NRET, 1, retire channels per cycle (1..4); channel 0 is oldest.
- DEPTH, 8, retirements to track before `check` pulses (2..255).
- IGNORE_MASK, 26'h0, per-field bit; 1 excludes that field from comparison (e.g. bit of R when refresh is modelled externally).
- STOP_ON_FAIL, 1, 1 = freeze counter and channel comparison after the first mismatch; 0 = keep counting and record only the first failure.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- arm  in  1  level; start tracking on the first cycle it is seen high while IDLE
- z80fi_valid  in  NRET  per-channel retire strobe
- z80fi_state_in  in  NRET*STATE_W  packed pre-execution state, channel k at [k*STATE_W +: STATE_W]
- z80fi_state_out  in  NRET*STATE_W  packed post-execution state, same layout
- check  out  1  one-cycle pulse in the cycle the DEPTH-th retirement is presented
- busy  out  1  high in TRACK
- fail  out  1  sticky mismatch or protocol error
- fail_proto  out  1  sticky; set when the valid vector is non-contiguous
- fail_chan  out  2  channel of the first failure
- fail_field  out  5  lowest-indexed mismatching field of the first failure (0 on a protocol failure)
- retired  out  8  consistent retirements counted, saturating at DEPTH

Behaviour:
- Reset (async, asserted): state=IDLE, shadow state=0, shadow_valid=0. All outputs 0.
- States:
  - IDLE -> TRACK when arm=1.
  - TRACK -> DONE when retired reaches DEPTH.
  - TRACK -> FAIL on first error if STOP_ON_FAIL=1; otherwise stay in TRACK with fail set.
  - DONE and FAIL hold until reset. arm is ignored outside IDLE.
- Retirement in IDLE: channels are only sampled in TRACK. A retirement in the same cycle arm rises is ignored; the first one counted arrives on the next edge.
- Valid contiguity:
  - Legal vectors are 0, or bit k set implies bit k-1 set.
  - Otherwise set fail_proto and fail, record fail_chan = lowest hole, and compare no channels that cycle.
- Reference selection for valid channel k:
  - k=0: the shadow register.
  - k>0: z80fi_state_out of channel k-1 in the same cycle.
- First retirement:
  - The first retirement in TRACK has shadow_valid=0, so channel 0 is not compared.
  - It is still counted.
- Compare: per field, `mismatch = (in != ref) & ~IGNORE_MASK[field]`. fail_field is the priority-encoded lowest mismatching index. The first failing channel wins; later channels in that cycle are not counted.
- Shadow update: on any cycle with n valid channels (n>0), shadow <= state_out of channel n-1 and shadow_valid <= 1.
- Counting and check:
  - retired += number of consistent valid channels, saturating at DEPTH.
  - check = combinational pulse, 1 in the cycle where retired + accepted_this_cycle crosses into DEPTH. Exactly one pulse per arm.
  - Retirements beyond DEPTH in that cycle are ignored.
- Width rule: `accepted_this_cycle` is 3 bits; the sum is computed in 9 bits before saturation.
- Reset mid-TRACK: all state is cleared asynchronously; `check` never pulses during reset.

Decomposition:
- Package `z80fi_seq_pkg`:
  - STATE_W = 210.
  - Field enum, 26 entries: IP, A, F, B, C, D, E, H, L, A2, F2, B2, C2, D2, E2, H2, L2, IX, IY, SP, I, R, IFF1, IFF2, plus two reserved codes.
  - Field offset/width constant arrays.
  - Checker state enum.
- Sub-module `z80fi_state_cmp`:
  - Combinational compare of one state pair against IGNORE_MASK.
  - Outputs a mismatch flag and the 5-bit field index.
  - Instantiated NRET times.

Test Plan:
- NRET=1, DEPTH=4; arm, then 4 chained retirements (IP 0x0000->0x0001->0x0003->0x0004->0x0007) -> check high only on the 4th valid cycle; retired=4; state DONE; fail=0.
- NRET=1; the 2nd retirement has state_in.A=0x12 against a previous out.A=0x13 -> fail=1, fail_field=A index (1), fail_chan=0, retired stays 1, check never pulses.
- NRET=2, DEPTH=3; cycle1 valid=2'b11 chained, cycle2 valid=2'b11 -> check pulses in cycle2; retired=3; the channel-1 retirement in cycle2 is ignored.
- NRET=4; valid=4'b0101 -> fail_proto=1, fail=1, fail_chan=1, retired unchanged.
- IGNORE_MASK with the R bit set; R differs by 0x7F between retirements -> no fail; clearing the mask with the same stimulus -> fail_field=R index (21).
- Reset asserted mid-TRACK with retired=3 -> all outputs 0 immediately (asynchronously); re-arm restarts the count from 0 and the first retirement is uncompared.
